// File: rtl/kbd_rx_fifo.sv
// Keyboard receive path: synchronises the nibble-strobe interface, assembles bytes and buffers them in a FIFO.
// Optional break-code filtering is enabled by defining KBD_BREAK_FILTER_EN.
module kbd_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_key,
  input  logic             kbd_enb_hi,
  input  logic             kbd_enb_lo,
  input  logic [3:0]       kbd_data,
  input  logic             int_ack,
  output logic             int_req,
  output logic [7:0]       kbd_ascii,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             proto_err
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_HAVE_HI = 1'b1
  } asm_state_e;

  // Bundled as {ack, lo, hi, data} so the nibble stays aligned with its strobe.
  logic [6:0]       sync_q [SYNC_STAGES];
  logic [6:0]       sync_out_s;
  logic [2:0]       prev_q;
  logic             hi_edge_s, lo_edge_s, ack_edge_s;
  logic [3:0]       nib_s;

  asm_state_e       state_q, state_d;
  logic [3:0]       hi_nib_q, hi_nib_d;
  logic             proto_err_q, proto_err_d;
  logic             byte_done_s;
  logic [7:0]       byte_s;
  logic             push_req_s;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             int_req_q, int_req_d;
  logic [7:0]       kbd_ascii_q, kbd_ascii_d;
  logic             full_s, pop_s, push_ok_s;

  // Synchroniser chain and edge-detect history.
  always_ff @(posedge clk or negedge rst_key) begin
    if (!rst_key) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 7'h00;
      end
      prev_q <= 3'b000;
    end else begin
      sync_q[0] <= {int_ack, kbd_enb_lo, kbd_enb_hi, kbd_data};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_out_s[6:4];
    end
  end

  assign sync_out_s = sync_q[SYNC_STAGES-1];
  assign nib_s      = sync_out_s[3:0];
  assign hi_edge_s  = sync_out_s[4] & ~prev_q[0];
  assign lo_edge_s  = sync_out_s[5] & ~prev_q[1];
  assign ack_edge_s = sync_out_s[6] & ~prev_q[2];

  // Byte assembler: steps only on detected strobe edges.
  always_comb begin
    state_d     = state_q;
    hi_nib_d    = hi_nib_q;
    proto_err_d = proto_err_q;
    byte_done_s = 1'b0;
    byte_s      = {hi_nib_q, nib_s};
    if (hi_edge_s && lo_edge_s) begin
      proto_err_d = 1'b1;
      state_d     = ST_IDLE;
    end else if (hi_edge_s) begin
      case (state_q)
        ST_IDLE:    proto_err_d = proto_err_q;
        ST_HAVE_HI: proto_err_d = 1'b1;
        default:    proto_err_d = 1'b1;
      endcase
      hi_nib_d = nib_s;
      state_d  = ST_HAVE_HI;
    end else if (lo_edge_s) begin
      case (state_q)
        ST_IDLE: begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
        ST_HAVE_HI: begin
          byte_done_s = 1'b1;
          state_d     = ST_IDLE;
        end
        default: begin
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge rst_key) begin
    if (!rst_key) begin
      state_q     <= ST_IDLE;
      hi_nib_q    <= 4'h0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_nib_q    <= hi_nib_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef KBD_BREAK_FILTER_EN
  logic skip_q, skip_d;

  // Break-code filter: drop 8'hF0 and the byte that follows it.
  always_comb begin
    skip_d     = skip_q;
    push_req_s = 1'b0;
    if (byte_done_s) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else if (byte_s == 8'hF0) begin
        skip_d = 1'b1;
      end else begin
        push_req_s = 1'b1;
      end
    end else begin
      push_req_s = 1'b0;
    end
  end

  // Filter skip flag.
  always_ff @(posedge clk or negedge rst_key) begin
    if (!rst_key) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
`else
  assign push_req_s = byte_done_s;
`endif

  // FIFO control; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    full_s      = (count_q == FULL_CNT);
    pop_s       = ack_edge_s && (count_q != ZERO_CNT);
    push_ok_s   = push_req_s && (!full_s || pop_s);
    overflow_d  = overflow_q | (push_req_s & full_s & ~pop_s);
    wr_ptr_d    = push_ok_s ? (wr_ptr_q + ONE_PTR) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    int_req_d = (count_d != ZERO_CNT);
    if (count_d == ZERO_CNT) begin
      kbd_ascii_d = 8'h00;
    end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      kbd_ascii_d = byte_s;
    end else begin
      kbd_ascii_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage, pointers, count and registered outputs.
  always_ff @(posedge clk or negedge rst_key) begin
    if (!rst_key) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= ZERO_CNT;
      overflow_q  <= 1'b0;
      int_req_q   <= 1'b0;
      kbd_ascii_q <= 8'h00;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= byte_s;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      int_req_q   <= int_req_d;
      kbd_ascii_q <= kbd_ascii_d;
    end
  end

  assign int_req    = int_req_q;
  assign kbd_ascii  = kbd_ascii_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign proto_err  = proto_err_q;

endmodule
